// File: rtl/expr_eval_ctrl_if.sv
// Handshake bundle between the character source, the evaluator and the result consumer.
interface expr_eval_ctrl_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic [7:0]   in_char;
  logic         in_ready;
  logic         res_valid;
  logic [W-1:0] res_value;
  logic         res_err;
  logic         res_ready;

  // Source / consumer side
  modport master (
    output in_valid, in_char, res_ready,
    input  in_ready, res_valid, res_value, res_err
  );

  // Evaluator side
  modport slave (
    input  in_valid, in_char, res_ready,
    output in_ready, res_valid, res_value, res_err
  );
endinterface

// File: rtl/expr_eval_ctrl.sv
// Streaming evaluator for single-digit expressions: digit ((+|*) digit)* '='.
// '*' binds tighter than '+'; all arithmetic wraps modulo 2^W.
//
// state   | meaning
// --------+--------------------------------------------------------
// S_START | waiting for the first digit of a new expression
// S_OP    | digit seen, expecting '+', '*' or '='
// S_DIG   | operator seen, expecting a digit
// S_ERR   | malformed or too long, discarding until '='
// S_RES   | result presented, waiting for res_ready (input stalled)
module expr_eval_ctrl #(
  parameter int W       = 16,
  parameter int MAX_LEN = 32
) (
  input  logic              clk,
  input  logic              clr,
  expr_eval_ctrl_if.slave   bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_9    = 8'h39;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;
  localparam logic [7:0] CH_EQ   = 8'h3D;

  typedef enum logic [2:0] {S_START, S_OP, S_DIG, S_ERR, S_RES} state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_sum, r_term, r_res_value;
  logic [W-1:0]  w_sum_nxt, w_term_nxt, w_res_value_nxt;
  logic          r_pend_mul, r_res_err, w_pend_mul_nxt, w_res_err_nxt;
  logic [LW-1:0] r_len, w_len_nxt;

  logic          w_accept, w_is_dig, w_is_eq, w_is_plus, w_is_mul, w_len_over;
  logic [7:0]    w_char_off;
  logic [W-1:0]  w_digit, w_prod;

  assign w_accept   = bus.in_valid && (r_state != S_RES);
  assign w_is_dig   = (bus.in_char >= CH_0) && (bus.in_char <= CH_9);
  assign w_is_eq    = (bus.in_char == CH_EQ);
  assign w_is_plus  = (bus.in_char == CH_PLUS);
  assign w_is_mul   = (bus.in_char == CH_MUL);
  assign w_char_off = bus.in_char - CH_0;
  assign w_digit    = W'(w_char_off[3:0]);
  assign w_prod     = r_term * w_digit;
  // A non-terminator arriving when len is already at the limit overflows the expression.
  assign w_len_over = !w_is_eq && (r_len == LEN_MAX);

  assign bus.in_ready  = (r_state != S_RES);
  assign bus.res_valid = (r_state == S_RES);
  assign bus.res_value = r_res_value;
  assign bus.res_err   = r_res_err;

  // Next-state and datapath updates for each accepted character or result release.
  always_comb begin
    w_state_nxt     = r_state;
    w_sum_nxt       = r_sum;
    w_term_nxt      = r_term;
    w_pend_mul_nxt  = r_pend_mul;
    w_len_nxt       = r_len;
    w_res_value_nxt = r_res_value;
    w_res_err_nxt   = r_res_err;

    if (w_accept) begin
      if (!w_is_eq && !w_len_over) begin
        w_len_nxt = r_len + LW'(1);
      end
      if (w_len_over) begin
        w_state_nxt = S_ERR;
      end else begin
        case (r_state)
          S_START: begin
            if (w_is_dig) begin
              w_term_nxt     = w_digit;
              w_sum_nxt      = '0;
              w_pend_mul_nxt = 1'b0;
              w_state_nxt    = S_OP;
            end else if (w_is_eq) begin
              w_res_value_nxt = '0;
              w_res_err_nxt   = 1'b1;
              w_state_nxt     = S_RES;
            end else begin
              w_state_nxt = S_ERR;
            end
          end
          S_OP: begin
            if (w_is_plus) begin
              w_sum_nxt      = r_sum + r_term;
              w_pend_mul_nxt = 1'b0;
              w_state_nxt    = S_DIG;
            end else if (w_is_mul) begin
              w_pend_mul_nxt = 1'b1;
              w_state_nxt    = S_DIG;
            end else if (w_is_eq) begin
              w_res_value_nxt = r_sum + r_term;
              w_res_err_nxt   = 1'b0;
              w_state_nxt     = S_RES;
            end else begin
              w_state_nxt = S_ERR;
            end
          end
          S_DIG: begin
            if (w_is_dig) begin
              w_term_nxt  = r_pend_mul ? w_prod : w_digit;
              w_state_nxt = S_OP;
            end else if (w_is_eq) begin
              w_res_value_nxt = '0;
              w_res_err_nxt   = 1'b1;
              w_state_nxt     = S_RES;
            end else begin
              w_state_nxt = S_ERR;
            end
          end
          S_ERR: begin
            if (w_is_eq) begin
              w_res_value_nxt = '0;
              w_res_err_nxt   = 1'b1;
              w_state_nxt     = S_RES;
            end
          end
          default: ;
        endcase
      end
    end else if ((r_state == S_RES) && bus.res_ready) begin
      w_state_nxt    = S_START;
      w_sum_nxt      = '0;
      w_term_nxt     = '0;
      w_pend_mul_nxt = 1'b0;
      w_len_nxt      = '0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_START;
    else     r_state <= w_state_nxt;
  end

  // Accumulators, length counter and held result.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_sum       <= '0;
      r_term      <= '0;
      r_pend_mul  <= 1'b0;
      r_len       <= '0;
      r_res_value <= '0;
      r_res_err   <= 1'b0;
    end else begin
      r_sum       <= w_sum_nxt;
      r_term      <= w_term_nxt;
      r_pend_mul  <= w_pend_mul_nxt;
      r_len       <= w_len_nxt;
      r_res_value <= w_res_value_nxt;
      r_res_err   <= w_res_err_nxt;
    end
  end
endmodule

// File: tb/tb_expr_eval_ctrl.sv
// Self-checking bench for expr_eval_ctrl: directed scenarios plus random expressions
// checked against a token-level reference evaluator.
module tb_expr_eval_ctrl;
  localparam int W       = 16;
  localparam int MAX_LEN = 32;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  expr_eval_ctrl_if #(.W(W)) bus ();

  expr_eval_ctrl #(.W(W), .MAX_LEN(MAX_LEN)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: validate grammar/length, then sum the '*'-products of '+'-separated terms.
  function automatic void model(input string s, output logic [W-1:0] v, output bit e);
    int          n;
    logic [W-1:0] terms[$];
    logic [W-1:0] acc;
    byte         c;
    n = s.len() - 1;
    e = (n < 1) || (n > MAX_LEN) || (n % 2 == 0);
    for (int i = 0; i < n; i++) begin
      c = s[i];
      if (i % 2 == 0) begin
        if (c < "0" || c > "9") e = 1;
      end else if (c != "+" && c != "*") begin
        e = 1;
      end
    end
    v = '0;
    if (!e) begin
      terms.push_back(W'(s[0] - "0"));
      for (int i = 1; i < n; i += 2) begin
        if (s[i] == "*") terms[terms.size()-1] = terms[terms.size()-1] * W'(s[i+1] - "0");
        else             terms.push_back(W'(s[i+1] - "0"));
      end
      acc = '0;
      foreach (terms[k]) acc = acc + terms[k];
      v = acc;
    end
  endfunction

  function automatic string gen_expr();
    string s;
    int    nt, p;
    byte   junk[4];
    byte   op;
    junk = '{"-", "x", "5", "+"};
    s  = "";
    nt = $urandom_range(1, 20);
    for (int i = 0; i < nt; i++) begin
      if (i > 0) begin
        op = ($urandom_range(0, 1) == 1) ? 8'h2A : 8'h2B;
        s  = $sformatf("%s%c", s, op);
      end
      s = $sformatf("%s%0d", s, $urandom_range(0, 9));
    end
    if ($urandom_range(0, 4) == 0) begin
      p = $urandom_range(0, s.len() - 1);
      s.putc(p, junk[$urandom_range(0, 3)]);
    end
    return {s, "="};
  endfunction

  // Called at a negedge; returns at the negedge after the character was accepted.
  task automatic send_char(input byte c);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fail++;
      $display("FAIL send_timeout char %c: in_ready stayed %b, required 1", c, bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic expr(input string s, input int hold, input bit gaps);
    logic [W-1:0] ev;
    bit           ee;
    model(s, ev, ee);
    bus.res_ready = (hold == 0);
    for (int i = 0; i < s.len(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      send_char(s[i]);
      if (i < s.len() - 1) begin
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL early_res_valid \"%s\" idx %0d: got %b, required 0", s, i, bus.res_valid);
        end
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL res_valid \"%s\": got %b, required 1", s, bus.res_valid);
    end
    n_checks++;
    if (bus.res_value !== ev) begin
      n_fail++;
      $display("FAIL res_value \"%s\": got %0d, required %0d", s, bus.res_value, ev);
    end
    n_checks++;
    if (bus.res_err !== ee) begin
      n_fail++;
      $display("FAIL res_err \"%s\": got %b, required %b", s, bus.res_err, ee);
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.res_value !== ev || bus.res_err !== ee) begin
        n_fail++;
        $display("FAIL hold_stable \"%s\" cycle %0d: valid/ready/value/err %b/%b/%0d/%b, required 1/0/%0d/%b",
                 s, k, bus.res_valid, bus.in_ready, bus.res_value, bus.res_err, ev, ee);
      end
    end
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL release \"%s\": res_valid/in_ready %b/%b, required 0/1", s, bus.res_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); end
    n_checks++;
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b, required 0", bus.res_valid); end
    n_checks++;
    if (bus.res_value !== '0) begin n_fail++; $display("FAIL reset_res_value: got %0d, required 0", bus.res_value); end
    n_checks++;
    if (bus.res_err !== 1'b0) begin n_fail++; $display("FAIL reset_res_err: got %b, required 0", bus.res_err); end
  endtask

  task automatic test_precedence();
    expr("3+4*5=", 0, 0);
    expr("2*3*4+1=", 0, 0);
    expr("9*9*9*9*9*9=", 0, 0);
    expr("0*7+8*2+1=", 0, 0);
  endtask

  task automatic test_errors();
    string errs[5];
    errs = '{"12+3=", "=", "4+=", "5-2=", "*3="};
    foreach (errs[i]) begin
      expr(errs[i], 0, 0);
      expr("2+2=", 0, 0);
    end
  endtask

  task automatic test_max_len();
    string s;
    s = "";
    repeat (33) s = {s, "1+"};
    expr({s, "1="}, 0, 0);
    expr("8=", 0, 0);
    s = "";
    repeat (15) s = {s, "1+"};
    expr({s, "1="}, 0, 0);
  endtask

  task automatic test_backpressure();
    bus.res_ready = 1'b0;
    send_char("7");
    send_char("=");
    bus.in_valid = 1'b1;
    bus.in_char  = "6";
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1 || bus.res_value !== 16'd7 || bus.res_err !== 1'b0) begin
        n_fail++;
        $display("FAIL stall cycle %0d: ready/valid/value/err %b/%b/%0d/%b, required 0/1/7/0",
                 k, bus.in_ready, bus.res_valid, bus.res_value, bus.res_err);
      end
      @(posedge clk); @(negedge clk);
    end
    bus.res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_release: in_ready/res_valid %b/%b, required 1/0", bus.in_ready, bus.res_valid);
    end
    expr("6=", 0, 0);
  endtask

  task automatic test_clr();
    bus.res_ready = 1'b1;
    send_char("9"); send_char("*"); send_char("9");
    bus.in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_mid_expr: res_valid/in_ready %b/%b, required 0/1", bus.res_valid, bus.in_ready);
    end
    expr("1=", 0, 0);
    bus.res_ready = 1'b0;
    send_char("5"); send_char("=");
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL clr_pending_pre: res_valid %b, required 1", bus.res_valid); end
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_value !== '0) begin
      n_fail++;
      $display("FAIL clr_pending: valid/ready/value %b/%b/%0d, required 0/1/0", bus.res_valid, bus.in_ready, bus.res_value);
    end
    expr("4*2=", 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      expr(gen_expr(), int'($urandom_range(0, 3)), 1'b1);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_char   = 8'h00;
    bus.res_ready = 1'b0;
    test_reset();
    test_precedence();
    test_errors();
    test_max_len();
    test_backpressure();
    test_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
